vote_accum_engine: RTL
======================

// Module: vote_accum_engine
// PURPOSE
// Parametrised vote accumulator placed after the tree-traversal cores. Folds per-sample
// classification label counts or regression values into an on-chip vote memory, one slot
// per sample. Read-modify-write with full forwarding, so back-to-back updates to the same
// address need no spacing. Saturating add, slot wrap and a clear-on-read readout port.
// PARAMETERS
// N_LABELS        16    max labels per sample (clf)
// N_LABELS_WIDTH  5     width of i_n_labels, must hold N_LABELS
// RES_WIDTH       16    vote/accumulator width, unsigned
// N_SLOTS         1024  sample slots in memory
// SLOT_WIDTH      10    clog2(N_SLOTS)
// SATURATE        1     1: clamp sums at 2^RES_WIDTH-1; 0: modulo wrap
// ADDR_WIDTH      14    localparam, clog2(N_SLOTS*N_LABELS)
// PORTS
// clk          in   1                    single clock, all logic posedge
// rst          in   1                    synchronous, active-high reset
// i_slot_rst   in   1                    next accepted sample goes to slot 0
// i_is_clf     in   1                    1 clf, 0 rgs; sampled on input accept
// i_n_labels   in   N_LABELS_WIDTH       labels in use; sampled on input accept
// i_accum_vld  in   1                    input sample valid
// o_accum_rdy  out  1                    input ready; accept = vld & rdy
// i_clf_accum  in   N_LABELS*RES_WIDTH   label counts, label k at [k*RES_WIDTH +: RES_WIDTH]
// i_rgs_accum  in   RES_WIDTH            regression value
// i_rd_req     in   1                    readout request
// o_rd_rdy     out  1                    readout ready; accept = req & rdy
// i_rd_addr    in   ADDR_WIDTH           word to read (and clear)
// o_rd_vld     out  1                    one-cycle pulse, readout data valid
// o_rd_data    out  RES_WIDTH            readout data
// o_busy       out  1                    serialiser active or RMW op in flight
// o_sat        out  1                    sticky: a saturation occurred
// o_wrap       out  1                    sticky: slot counter wrapped
// BEHAVIOUR
// - Reset: FSM IDLE, slot=0, base=0, pipeline valids=0. o_accum_rdy=1, o_rd_rdy=1,
//   o_rd_vld=0, o_rd_data=0, o_busy=0, o_sat=0, o_wrap=0. Memory not cleared.
//   Reset mid-operation drops all in-flight ops.
// - i_n_labels outside 1..N_LABELS is treated as N_LABELS.
// - FSM IDLE/SER. IDLE: accepted clf sample latches the vector, n_labels and base, then
//   goes to SER. SER issues one op per cycle for labels 0..n-1 at addr base+k. On the last
//   label: base+=n, slot+=1, back to IDLE. o_accum_rdy=0 in SER, so clf throughput is one
//   sample per n_labels+1 cycles. n=1: one SER cycle.
// - rgs: no SER state. One op per accepted cycle at addr=slot, slot+=1. o_accum_rdy
//   stays 1, so one sample per cycle.
// - Slot wrap: after slot N_SLOTS-1, slot=0, base=0 and o_wrap is set.
// - i_slot_rst: next accepted sample uses slot 0 / base 0. If it arrives in the same cycle
//   as an accept, that accept already uses slot 0. In-flight ops complete unaffected.
// - RMW pipeline: S0 issue (addr, val) -> S1 RAM read (1-cycle sync) -> S2 add+write.
//   Write lands 2 cycles after issue.
// - Forwarding, priority S2 > S3: S1 read data is replaced by the S2 result when addresses
//   match, else by the value written the previous cycle (S3 holding reg) when those match.
//   Back-to-back same-address ops must sum exactly.
// - Add: sum = mem + val, RES_WIDTH+1 bits. If SATURATE and carry: write all-ones and set
//   o_sat. Else write the low RES_WIDTH bits.
// - o_busy = FSM in SER | any S0..S2 valid.
// - Readout: o_rd_rdy = ~o_busy & ~i_accum_vld. A request in the same cycle as an input
//   accept: the input wins. Request accepted at cycle T: RAM read at T+1, zero written to
//   that address at T+1, o_rd_vld=1 and o_rd_data at T+2. o_accum_rdy=0 during T+1.
// - o_rd_data holds its value until the next readout.
// TESTING
// 1 rgs, 4 back-to-back samples 5,7,9,11 after clearing slots 0..3: read slots 0..3 ->
//   5,7,9,11; a second read -> 0 (clear-on-read).
// 2 clf, n_labels=3, two samples {1,2,3} then {4,5,6}: addresses 0..5 read 1,2,3,4,5,6;
//   o_accum_rdy low 3 cycles per sample.
// 3 Forwarding: rgs with i_slot_rst pulsed each cycle, 6 consecutive samples of 10 to
//   slot 0 -> slot 0 reads 60.
// 4 SATURATE=1, RES_WIDTH=16: slot holds 65530, add 10 -> reads 65535 and o_sat=1;
//   SATURATE=0 -> reads 4.
// 5 N_SLOTS=4 rgs, 5 samples of 1 -> o_wrap=1, slot 0 reads 2, slots 1..3 read 1.
// 6 rst asserted mid-SER with n_labels=8 -> next cycle o_busy=0, o_accum_rdy=1, flags 0,
//   and later samples start at slot 0.

Source files
------------

// File: rtl/vote_accum_if.sv
// vote_accum_if: sample input, readout and status signals of vote_accum_engine
interface vote_accum_if #(
  parameter int N_LABELS       = 16,
  parameter int N_LABELS_WIDTH = 5,
  parameter int RES_WIDTH      = 16,
  parameter int ADDR_WIDTH     = 14
);
  logic                          i_slot_rst;
  logic                          i_is_clf;
  logic [N_LABELS_WIDTH-1:0]     i_n_labels;
  logic                          i_accum_vld;
  logic                          o_accum_rdy;
  logic [N_LABELS*RES_WIDTH-1:0] i_clf_accum;
  logic [RES_WIDTH-1:0]          i_rgs_accum;
  logic                          i_rd_req;
  logic                          o_rd_rdy;
  logic [ADDR_WIDTH-1:0]         i_rd_addr;
  logic                          o_rd_vld;
  logic [RES_WIDTH-1:0]          o_rd_data;
  logic                          o_busy;
  logic                          o_sat;
  logic                          o_wrap;
  modport master (
    output i_slot_rst, i_is_clf, i_n_labels, i_accum_vld, i_clf_accum, i_rgs_accum, i_rd_req, i_rd_addr,
    input  o_accum_rdy, o_rd_rdy, o_rd_vld, o_rd_data, o_busy, o_sat, o_wrap
  );
  modport slave (
    input  i_slot_rst, i_is_clf, i_n_labels, i_accum_vld, i_clf_accum, i_rgs_accum, i_rd_req, i_rd_addr,
    output o_accum_rdy, o_rd_rdy, o_rd_vld, o_rd_data, o_busy, o_sat, o_wrap
  );
endinterface

// File: rtl/vote_accum_engine.sv
// vote_accum_engine: per-sample vote accumulation with forwarded RMW, saturation and clear-on-read
module vote_accum_engine #(
  parameter int N_LABELS       = 16,
  parameter int N_LABELS_WIDTH = 5,
  parameter int RES_WIDTH      = 16,
  parameter int N_SLOTS        = 1024,
  parameter int SLOT_WIDTH     = 10,
  parameter bit SATURATE       = 1'b1
) (
  input logic         clk,
  input logic         rst,
  vote_accum_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(N_SLOTS * N_LABELS);
  typedef enum logic {IDLE, SER} state_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [RES_WIDTH-1:0] res_t;
  typedef struct packed {
    logic  vld;
    addr_t addr;
    res_t  val;
  } op_t;

  state_t                        state_q, state_d;
  logic [SLOT_WIDTH-1:0]         slot_q, slot_d, eff_slot, cur_slot;
  addr_t                         base_q, base_d, eff_base, cur_base, rd_addr_q, rd_addr_d;
  logic [N_LABELS*RES_WIDTH-1:0] vec_q, vec_d;
  logic [N_LABELS_WIDTH-1:0]     n_q, n_d, k_q, k_d, n_in;
  logic                          pend_q, pend_d, sat_q, sat_d, wrap_q, wrap_d;
  logic                          rd1_q, rd1_d, rd_vld_q, rd_vld_d;
  res_t                          rd_data_q, rd_data_d, ram_q, ram_d, s2_old_q, s2_old_d, wr_data;
  op_t                           s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [RES_WIDTH:0]            sum;
  logic                          accept, rd_acc, accum_rdy, busy, bump, ovf;
  res_t                          mem [N_SLOTS*N_LABELS];

  assign accum_rdy       = (state_q == IDLE) & ~rd1_q;
  assign busy            = (state_q == SER) | s1_q.vld | s2_q.vld;
  assign accept          = bus.i_accum_vld & accum_rdy;
  assign rd_acc          = bus.i_rd_req & bus.o_rd_rdy;
  assign eff_slot        = (bus.i_slot_rst | pend_q) ? '0 : slot_q;
  assign eff_base        = (bus.i_slot_rst | pend_q) ? '0 : base_q;
  assign n_in            = (bus.i_n_labels == '0 || bus.i_n_labels > N_LABELS_WIDTH'(N_LABELS)) ?
                           N_LABELS_WIDTH'(N_LABELS) : bus.i_n_labels;
  assign bus.o_accum_rdy = accum_rdy;
  assign bus.o_busy      = busy;
  assign bus.o_rd_rdy    = ~busy & ~bus.i_accum_vld;
  assign bus.o_rd_vld    = rd_vld_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_sat       = sat_q;
  assign bus.o_wrap      = wrap_q;

  // s1_d is the S0 op issued this cycle; a pending slot reset waits for the next accepted sample
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    base_d   = base_q;
    vec_d    = vec_q;
    n_d      = n_q;
    k_d      = k_q;
    pend_d   = pend_q | bus.i_slot_rst;
    wrap_d   = wrap_q;
    s1_d     = '0;
    bump     = 1'b0;
    cur_slot = eff_slot;
    cur_base = eff_base;
    if (state_q == SER) begin
      s1_d = '{1'b1, base_q + addr_t'(k_q), vec_q[k_q*RES_WIDTH +: RES_WIDTH]};
      k_d  = k_q + 1'b1;
      if (k_q == n_q - 1'b1) begin
        state_d  = IDLE;
        bump     = 1'b1;
        cur_slot = slot_q;
        cur_base = base_q + addr_t'(n_q);
      end
    end else if (accept) begin
      pend_d = 1'b0;
      if (bus.i_is_clf) begin
        state_d = SER;
        vec_d   = bus.i_clf_accum;
        n_d     = n_in;
        k_d     = '0;
        slot_d  = eff_slot;
        base_d  = eff_base;
      end else begin
        s1_d = '{1'b1, addr_t'(eff_slot), bus.i_rgs_accum};
        bump = 1'b1;
      end
    end
    if (bump) begin
      wrap_d = wrap_q | (cur_slot == SLOT_WIDTH'(N_SLOTS - 1));
      slot_d = (cur_slot == SLOT_WIDTH'(N_SLOTS - 1)) ? '0 : cur_slot + 1'b1;
      base_d = (cur_slot == SLOT_WIDTH'(N_SLOTS - 1)) ? '0 : cur_base;
    end
  end

  // S2 result beats the S3 holding reg: it is the newer write to a matching address
  always_comb begin
    ram_d     = mem[s1_d.addr];
    sum       = {1'b0, s2_old_q} + {1'b0, s2_q.val};
    ovf       = SATURATE && sum[RES_WIDTH];
    wr_data   = ovf ? '1 : sum[RES_WIDTH-1:0];
    sat_d     = sat_q | (s2_q.vld & ovf);
    s2_d      = s1_q;
    s2_old_d  = (s2_q.vld && s2_q.addr == s1_q.addr) ? wr_data :
                (s3_q.vld && s3_q.addr == s1_q.addr) ? s3_q.val : ram_q;
    s3_d      = '{s2_q.vld, s2_q.addr, wr_data};
    rd1_d     = rd_acc;
    rd_addr_d = rd_acc ? bus.i_rd_addr : rd_addr_q;
    rd_vld_d  = rd1_q;
    rd_data_d = rd1_q ? mem[rd_addr_q] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      base_q    <= '0;
      pend_q    <= 1'b0;
      sat_q     <= 1'b0;
      wrap_q    <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      rd1_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      base_q    <= base_d;
      pend_q    <= pend_d;
      sat_q     <= sat_d;
      wrap_q    <= wrap_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      rd1_q     <= rd1_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    vec_q     <= vec_d;
    n_q       <= n_d;
    k_q       <= k_d;
    s2_old_q  <= s2_old_d;
    rd_addr_q <= rd_addr_d;
    ram_q     <= ram_d;
    if (!rst && s2_q.vld) mem[s2_q.addr] <= wr_data;
    else if (!rst && rd1_q) mem[rd_addr_q] <= '0;
  end
endmodule
